// File: rtl/sad_ctrl_pkg.sv
// Shared types and constants for the SAD full-search controller.
//   state_t  : controller FSM encoding (IDLE/FIRST/SCAN/DONE, 2 bits)
//   num_pos  : number of search positions in a WIN_H x WIN_W window
//   SAD_MAX  : all-ones SAD seed, truncated by users to their SAD width (<= 64)
package sad_ctrl_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned SAD_MAX_W  = 64;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [SAD_MAX_W-1:0] SAD_MAX = '1;

    function automatic int unsigned num_pos(input int unsigned win_w,
                                            input int unsigned win_h);
        return win_w * win_h;
    endfunction

endpackage

// File: rtl/sad_pos_counter.sv
// Raster-order (column fastest) search-position counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : return to position (0,0); has priority over inc
//   inc       : advance one position; holds at the last position
//   row, col  : current position (registered)
//   last_c    : current position is the final one in the window
module sad_pos_counter #(
    parameter int unsigned WIN_W   = 16,
    parameter int unsigned WIN_H   = 16,
    parameter int unsigned COORD_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               last_c
);

    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(WIN_W - 1);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(WIN_H - 1);

    assign last_c = (row == ROW_MAX) && (col == COL_MAX);

    // Position register; never wraps past the final position.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc && !last_c) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + COORD_W'(1);
            end else begin
                col <= col + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation pass controller over a WIN_H x WIN_W window.
// Takes one candidate SAD per position in raster order, tracks the running
// minimum and its position, and drives the candidate/best SAD mux select.
// Optional feature: define SAD_EARLY_EXIT_EN to end the pass as soon as a
// zero SAD is accepted (remaining positions are skipped).
// Ports:
//   Clk, Rst          : clock, synchronous active-high reset
//   Start             : begin a pass (only honoured in IDLE)
//   SadIn, SadValid   : candidate SAD for the current position
//   SadReady          : candidate can be accepted this cycle
//   CurRow, CurCol    : position awaited / being accepted
//   MuxSel            : combinational, 1 = take candidate, 0 = hold best
//   BestSad/Row/Col   : running / final minimum and its position
//   Busy              : pass in progress
//   Done              : one-cycle pulse once the pass has completed
module sad_search_ctrl
    import sad_ctrl_pkg::*;
#(
    parameter int unsigned SAD_W   = 32,
    parameter int unsigned WIN_W   = 16,
    parameter int unsigned WIN_H   = 16,
    parameter int unsigned COORD_W = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [SAD_W-1:0]   SadIn,
    input  logic               SadValid,
    output logic               SadReady,
    output logic [COORD_W-1:0] CurRow,
    output logic [COORD_W-1:0] CurCol,
    output logic               MuxSel,
    output logic [SAD_W-1:0]   BestSad,
    output logic [COORD_W-1:0] BestRow,
    output logic [COORD_W-1:0] BestCol,
    output logic               Busy,
    output logic               Done
);

    localparam int unsigned NUM_POS = num_pos(WIN_W, WIN_H);

    state_t state;
    state_t next_state;

    logic accept_c;
    logic better_c;
    logic zero_exit_c;
    logic last_c;
    logic cnt_clr_c;
    logic cnt_inc_c;

`ifdef SAD_EARLY_EXIT_EN
    assign zero_exit_c = (SadIn == '0);
`else
    assign zero_exit_c = 1'b0;
`endif

    sad_pos_counter #(
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H),
        .COORD_W (COORD_W)
    ) u_pos (
        .clk    (Clk),
        .rst    (Rst),
        .clr    (cnt_clr_c),
        .inc    (cnt_inc_c),
        .row    (CurRow),
        .col    (CurCol),
        .last_c (last_c)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, accept handshake, mux select and counter control.
    always_comb begin
        next_state = state;
        accept_c   = SadValid && SadReady;
        better_c   = SadIn < BestSad;
        MuxSel     = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    next_state = FIRST;
                    cnt_clr_c  = 1'b1;
                end
            end
            FIRST: begin
                if (accept_c) begin
                    MuxSel     = 1'b1;
                    next_state = (NUM_POS == 1 || zero_exit_c) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (accept_c) begin
                    MuxSel = better_c;
                    if (last_c || zero_exit_c) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Freeze the position on an early-exit zero so it reports where it hit.
        cnt_inc_c = accept_c && !zero_exit_c;
    end

    // Status outputs, registered as a decode of the upcoming state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            SadReady <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            SadReady <= (next_state == FIRST) || (next_state == SCAN);
            Busy     <= (next_state != IDLE);
            Done     <= (next_state == DONE);
        end
    end

    // Best-so-far tracking; MuxSel already encodes first-or-strictly-better.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            BestSad <= SAD_W'(SAD_MAX);
            BestRow <= '0;
            BestCol <= '0;
        end else if (MuxSel) begin
            BestSad <= SadIn;
            BestRow <= CurRow;
            BestCol <= CurCol;
        end
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed self-checking bench for sad_search_ctrl on a 2x2 window.
module tb_sad_search_ctrl;

    localparam int unsigned SAD_W   = 32;
    localparam int unsigned COORD_W = 5;

    logic               clk;
    logic               rst;
    logic               start;
    logic [SAD_W-1:0]   sad_in;
    logic               sad_valid;
    logic               sad_ready;
    logic [COORD_W-1:0] cur_row;
    logic [COORD_W-1:0] cur_col;
    logic               mux_sel;
    logic [SAD_W-1:0]   best_sad;
    logic [COORD_W-1:0] best_row;
    logic [COORD_W-1:0] best_col;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;

    sad_search_ctrl #(
        .SAD_W   (SAD_W),
        .WIN_W   (2),
        .WIN_H   (2),
        .COORD_W (COORD_W)
    ) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Start    (start),
        .SadIn    (sad_in),
        .SadValid (sad_valid),
        .SadReady (sad_ready),
        .CurRow   (cur_row),
        .CurCol   (cur_col),
        .MuxSel   (mux_sel),
        .BestSad  (best_sad),
        .BestRow  (best_row),
        .BestCol  (best_col),
        .Busy     (busy),
        .Done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a candidate and let combinational outputs settle.
    task automatic present(input logic [SAD_W-1:0] v);
        sad_in    = v;
        sad_valid = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        sad_valid = 1'b0;
        sad_in    = '0;
    endtask

    task automatic begin_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; idle_inputs();
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++;
        if (sad_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mux_sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got ready=%b busy=%b done=%b mux=%b exp all 0",
                     sad_ready, busy, done, mux_sel);
        end
        checks++;
        if (best_sad !== 32'hFFFF_FFFF || best_row !== 5'd0 || best_col !== 5'd0 ||
            cur_row !== 5'd0 || cur_col !== 5'd0) begin
            failures++;
            $display("FAIL reset_best got best=%0h (%0d,%0d) cur=(%0d,%0d) exp ffffffff (0,0) (0,0)",
                     best_sad, best_row, best_col, cur_row, cur_col);
        end
    endtask

    task automatic test_basic();
        begin_pass();
        checks++;
        if (sad_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_first got ready=%b busy=%b done=%b exp 1 1 0", sad_ready, busy, done);
        end
        present(32'd9);
        checks++;
        if (mux_sel !== 1'b1 || cur_col !== 5'd0) begin
            failures++;
            $display("FAIL basic_mux0 got mux=%b col=%0d exp 1 0", mux_sel, cur_col);
        end
        tick(); present(32'd5);
        checks++;
        if (mux_sel !== 1'b1 || cur_row !== 5'd0 || cur_col !== 5'd1) begin
            failures++;
            $display("FAIL basic_mux1 got mux=%b pos=(%0d,%0d) exp 1 (0,1)", mux_sel, cur_row, cur_col);
        end
        tick(); present(32'd7);
        checks++;
        if (mux_sel !== 1'b0 || cur_row !== 5'd1 || cur_col !== 5'd0) begin
            failures++;
            $display("FAIL basic_mux2 got mux=%b pos=(%0d,%0d) exp 0 (1,0)", mux_sel, cur_row, cur_col);
        end
        tick(); present(32'd3);
        checks++;
        if (mux_sel !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_mux3 got mux=%b done=%b exp 1 0", mux_sel, done);
        end
        tick(); idle_inputs(); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || sad_ready !== 1'b0 || mux_sel !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got done=%b busy=%b ready=%b mux=%b exp 1 1 0 0",
                     done, busy, sad_ready, mux_sel);
        end
        checks++;
        if (best_sad !== 32'd3 || best_row !== 5'd1 || best_col !== 5'd1) begin
            failures++;
            $display("FAIL basic_best got %0d (%0d,%0d) exp 3 (1,1)", best_sad, best_row, best_col);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || best_sad !== 32'd3) begin
            failures++;
            $display("FAIL basic_idle got done=%b busy=%b best=%0d exp 0 0 3", done, busy, best_sad);
        end
    endtask

    task automatic test_ties();
        logic [SAD_W-1:0] v [4];
        logic             m [4];
        v = '{32'd4, 32'd4, 32'd6, 32'd4};
        m = '{1'b1, 1'b0, 1'b0, 1'b0};
        begin_pass();
        for (int i = 0; i < 4; i++) begin
            present(v[i]);
            checks++;
            if (mux_sel !== m[i]) begin
                failures++;
                $display("FAIL ties_mux%0d got %b exp %b", i, mux_sel, m[i]);
            end
            tick();
        end
        idle_inputs(); #1;
        checks++;
        if (done !== 1'b1 || best_sad !== 32'd4 || best_row !== 5'd0 || best_col !== 5'd0) begin
            failures++;
            $display("FAIL ties_best got done=%b %0d (%0d,%0d) exp 1 4 (0,0)",
                     done, best_sad, best_row, best_col);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [SAD_W-1:0] v [4];
        v = '{32'd9, 32'd5, 32'd7, 32'd3};
        begin_pass();
        for (int i = 0; i < 4; i++) begin
            present(v[i]);
            tick();
            if (i < 3) begin
                // A tiny SAD on a non-valid cycle must neither be taken nor selected.
                sad_valid = 1'b0;
                sad_in    = 32'd1;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    checks++;
                    if (mux_sel !== 1'b0 || sad_ready !== 1'b1 || done !== 1'b0 ||
                        {cur_row, cur_col} !== {5'(i + 1) >> 1, 5'((i + 1) & 1)}) begin
                        failures++;
                        $display("FAIL stall_hold%0d_%0d got mux=%b ready=%b done=%b pos=(%0d,%0d)",
                                 i, s, mux_sel, sad_ready, done, cur_row, cur_col);
                    end
                    tick();
                end
            end
        end
        idle_inputs(); #1;
        checks++;
        if (done !== 1'b1 || best_sad !== 32'd3 || best_row !== 5'd1 || best_col !== 5'd1) begin
            failures++;
            $display("FAIL stall_best got done=%b %0d (%0d,%0d) exp 1 3 (1,1)",
                     done, best_sad, best_row, best_col);
        end
        tick();
    endtask

    task automatic test_reset_mid_pass();
        logic [SAD_W-1:0] v [4];
        logic             m [4];
        begin_pass();
        present(32'd2);
        tick();
        present(32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sad_ready !== 1'b0 || best_sad !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL rstmid_state got busy=%b done=%b ready=%b best=%0h exp 0 0 0 ffffffff",
                     busy, done, sad_ready, best_sad);
        end
        tick(); tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_nodone got done=%b busy=%b exp 0 0", done, busy);
        end
        v = '{32'd6, 32'd2, 32'd8, 32'd1};
        m = '{1'b1, 1'b1, 1'b0, 1'b1};
        begin_pass();
        checks++;
        if (cur_row !== 5'd0 || cur_col !== 5'd0 || sad_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_restart got pos=(%0d,%0d) ready=%b exp (0,0) 1", cur_row, cur_col, sad_ready);
        end
        for (int i = 0; i < 4; i++) begin
            present(v[i]);
            checks++;
            if (mux_sel !== m[i]) begin
                failures++;
                $display("FAIL rstmid_mux%0d got %b exp %b", i, mux_sel, m[i]);
            end
            tick();
        end
        idle_inputs(); #1;
        checks++;
        if (done !== 1'b1 || best_sad !== 32'd1 || best_row !== 5'd1 || best_col !== 5'd1) begin
            failures++;
            $display("FAIL rstmid_best got done=%b %0d (%0d,%0d) exp 1 1 (1,1)",
                     done, best_sad, best_row, best_col);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        begin_pass();
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(SAD_W'(10 * (i + 1)));
            tick();
            if (i == 0) begin
                checks++;
                if (cur_col !== 5'd1 || cur_row !== 5'd0) begin
                    failures++;
                    $display("FAIL busy_start_pos got (%0d,%0d) exp (0,1)", cur_row, cur_col);
                end
            end
            if (i < 3) begin
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_early_done%0d got done=1 exp 0", i);
                end
            end
        end
        idle_inputs(); #1;
        checks++;
        if (done !== 1'b1 || best_sad !== 32'd10 || best_row !== 5'd0 || best_col !== 5'd0) begin
            failures++;
            $display("FAIL busy_done got done=%b %0d (%0d,%0d) exp 1 10 (0,0)",
                     done, best_sad, best_row, best_col);
        end
        // Start still high while in DONE: must fall back to IDLE.
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || sad_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL busy_after got busy=%b ready=%b done=%b exp 0 0 0", busy, sad_ready, done);
        end
        tick();
    endtask

    task automatic test_early_exit();
        begin_pass();
        present(32'd8);
        tick();
        present(32'd0);
        checks++;
        if (mux_sel !== 1'b1) begin
            failures++;
            $display("FAIL exit_mux got %b exp 1", mux_sel);
        end
        tick();
`ifdef SAD_EARLY_EXIT_EN
        idle_inputs(); #1;
        checks++;
        if (done !== 1'b1 || cur_row !== 5'd0 || cur_col !== 5'd1) begin
            failures++;
            $display("FAIL exit_done got done=%b pos=(%0d,%0d) exp 1 (0,1)", done, cur_row, cur_col);
        end
`else
        checks++;
        if (done !== 1'b0 || sad_ready !== 1'b1) begin
            failures++;
            $display("FAIL exit_none got done=%b ready=%b exp 0 1", done, sad_ready);
        end
        present(32'd5);
        tick();
        present(32'd0);
        checks++;
        if (mux_sel !== 1'b0) begin
            failures++;
            $display("FAIL exit_tie_mux got %b exp 0", mux_sel);
        end
        tick();
        idle_inputs(); #1;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL exit_full_done got done=%b exp 1", done);
        end
`endif
        checks++;
        if (best_sad !== 32'd0 || best_row !== 5'd0 || best_col !== 5'd1) begin
            failures++;
            $display("FAIL exit_best got %0d (%0d,%0d) exp 0 (0,1)", best_sad, best_row, best_col);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_stall();
        test_reset_mid_pass();
        test_start_while_busy();
        test_early_exit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
